// File: rtl/panda_risc_v_pkg.sv
// Shared definitions for the panda_risc_v core: CSR update encodings, retire-lane
// field widths, the buffered CSR write record and a clog2 helper.
package panda_risc_v_pkg;

    localparam int RD_ID_W        = 5;
    localparam int CSR_ADDR_W     = 12;
    localparam int CSR_UPD_TYPE_W = 2;
    localparam int CSR_DATA_W     = 32;

    localparam logic [CSR_UPD_TYPE_W-1:0] CSR_UPD_WRITE = 2'b00;
    localparam logic [CSR_UPD_TYPE_W-1:0] CSR_UPD_SET   = 2'b01;
    localparam logic [CSR_UPD_TYPE_W-1:0] CSR_UPD_CLR   = 2'b10;

    typedef struct packed {
        logic [CSR_ADDR_W-1:0]     waddr;
        logic [CSR_UPD_TYPE_W-1:0] upd_type;
        logic [CSR_DATA_W-1:0]     upd_mask_v;
    } csr_wr_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v)
            r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/panda_risc_v_wbck_csr_buf.sv
// One-entry ready/valid buffer for the retiring CSR write. A load in the same
// cycle as a drain replaces the entry and keeps it pending.
module panda_risc_v_wbck_csr_buf
    import panda_risc_v_pkg::*;
(
    input  logic    clk,
    input  logic    sys_reset,
    input  logic    ld,
    input  csr_wr_t ld_data,
    input  logic    rdy,
    output logic    pend,
    output csr_wr_t data
);

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            pend <= 1'b0;
            data <= '0;
        end else if (ld) begin
            pend <= 1'b1;
            data <= ld_data;
        end else if (rdy & pend) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/panda_risc_v_wbck_mr.sv
// Multi-lane retire write-back: exception squash, same-rd collision resolution,
// CSR buffering and retire count. PANDA_RISC_V_WBCK_OUT_REG_EN registers the RF ports.
module panda_risc_v_wbck_mr
    import panda_risc_v_pkg::*;
#(
    parameter int RTR_WIDTH    = 2,
    parameter int FU_RES_WIDTH = 32,
    localparam int CNT_W       = clog2(RTR_WIDTH + 1)
)(
    input  logic                                  clk,
    input  logic                                  sys_reset,
    input  logic [RTR_WIDTH-1:0]                  rob_rtr_lane_vld,
    input  logic [RD_ID_W*RTR_WIDTH-1:0]          rob_rtr_rd_id,
    input  logic [RTR_WIDTH-1:0]                  rob_rtr_is_csr_rw_inst,
    input  logic [RTR_WIDTH-1:0]                  rob_rtr_cancel,
    input  logic [FU_RES_WIDTH*RTR_WIDTH-1:0]     rob_rtr_fu_res,
    input  logic [CSR_ADDR_W*RTR_WIDTH-1:0]       rob_rtr_csr_waddr,
    input  logic [CSR_UPD_TYPE_W*RTR_WIDTH-1:0]   rob_rtr_csr_upd_type,
    input  logic [CSR_DATA_W*RTR_WIDTH-1:0]       rob_rtr_csr_upd_mask_v,
    input  logic                                  rob_rtr_bdcst_vld,
    output logic                                  rob_rtr_bdcst_rdy,
    input  logic [RTR_WIDTH-1:0]                  rob_rtr_excpt_proc_grant,
    output logic [RTR_WIDTH-1:0]                  reg_file_wen,
    output logic [RD_ID_W*RTR_WIDTH-1:0]          reg_file_waddr,
    output logic [32*RTR_WIDTH-1:0]               reg_file_din,
    output logic                                  csr_atom_wen,
    input  logic                                  csr_atom_rdy,
    output logic [CSR_ADDR_W-1:0]                 csr_atom_waddr,
    output logic [CSR_UPD_TYPE_W-1:0]             csr_atom_upd_type,
    output logic [CSR_DATA_W-1:0]                 csr_atom_upd_mask_v,
    output logic                                  csr_wbck_pend,
    output logic [CNT_W-1:0]                      rtr_cnt
);

    logic [RTR_WIDTH-1:0][RD_ID_W-1:0]        rd;
    logic [RTR_WIDTH-1:0][FU_RES_WIDTH-1:0]   res;
    logic [RTR_WIDTH-1:0][CSR_ADDR_W-1:0]     c_addr;
    logic [RTR_WIDTH-1:0][CSR_UPD_TYPE_W-1:0] c_type;
    logic [RTR_WIDTH-1:0][CSR_DATA_W-1:0]     c_mask;
    logic [RTR_WIDTH-1:0][31:0]               din_c;
    logic [RTR_WIDTH-1:0]                     live, en, wen_c;
    logic                                     acc, kill_seen, csr_pend, csr_ld;
    logic [CNT_W-1:0]                         cnt_c;
    csr_wr_t                                  csr_sel, csr_q;

    assign rd     = rob_rtr_rd_id;
    assign res    = rob_rtr_fu_res;
    assign c_addr = rob_rtr_csr_waddr;
    assign c_type = rob_rtr_csr_upd_type;
    assign c_mask = rob_rtr_csr_upd_mask_v;

    // No group is taken while in reset so every output reads 0 there.
    assign rob_rtr_bdcst_rdy = ~sys_reset & (~csr_pend | csr_atom_rdy);
    assign acc               = rob_rtr_bdcst_vld & rob_rtr_bdcst_rdy;

    // The granted lane and every younger lane are killed.
    always_comb begin
        kill_seen = 1'b0;
        live      = '0;
        for (int k = 0; k < RTR_WIDTH; k++) begin
            if (rob_rtr_excpt_proc_grant[k] & rob_rtr_lane_vld[k])
                kill_seen = 1'b1;
            live[k] = acc & rob_rtr_lane_vld[k] & ~rob_rtr_cancel[k] & ~kill_seen;
        end
    end

    // Same-rd collision: a younger enabled lane masks every older one.
    always_comb begin
        wen_c = '0;
        for (int k = 0; k < RTR_WIDTH; k++) begin
            wen_c[k] = en[k];
            for (int j = k + 1; j < RTR_WIDTH; j++)
                if (en[j] && rd[j] == rd[k])
                    wen_c[k] = 1'b0;
        end
    end

    for (genvar k = 0; k < RTR_WIDTH; k++) begin : g_lane
        assign en[k]    = live[k] & (|rd[k]);
        assign din_c[k] = res[k][31:0];
    end

    always_comb begin
        cnt_c = '0;
        for (int k = 0; k < RTR_WIDTH; k++)
            cnt_c = cnt_c + CNT_W'(live[k]);
    end

    // Oldest live CSR lane wins; later CSR lanes still write the RF.
    always_comb begin
        csr_ld  = 1'b0;
        csr_sel = '0;
        for (int k = 0; k < RTR_WIDTH; k++) begin
            if (live[k] & rob_rtr_is_csr_rw_inst[k] & ~csr_ld) begin
                csr_ld  = 1'b1;
                csr_sel = '{waddr: c_addr[k], upd_type: c_type[k], upd_mask_v: c_mask[k]};
            end
        end
    end

`ifdef PANDA_RISC_V_WBCK_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            reg_file_wen   <= '0;
            reg_file_waddr <= '0;
            reg_file_din   <= '0;
        end else begin
            reg_file_wen   <= wen_c;
            reg_file_waddr <= rd;
            reg_file_din   <= din_c;
        end
    end
`else
    assign reg_file_wen   = wen_c;
    assign reg_file_waddr = rd;
    assign reg_file_din   = din_c;
`endif

    always_ff @(posedge clk) begin
        if (sys_reset)
            rtr_cnt <= '0;
        else
            rtr_cnt <= cnt_c;
    end

    panda_risc_v_wbck_csr_buf u_csr_buf (
        .clk       (clk),
        .sys_reset (sys_reset),
        .ld        (csr_ld),
        .ld_data   (csr_sel),
        .rdy       (csr_atom_rdy),
        .pend      (csr_pend),
        .data      (csr_q)
    );

    assign csr_atom_wen        = csr_pend;
    assign csr_wbck_pend       = csr_pend;
    assign csr_atom_waddr      = csr_q.waddr;
    assign csr_atom_upd_type   = csr_q.upd_type;
    assign csr_atom_upd_mask_v = csr_q.upd_mask_v;

endmodule

// File: tb/tb_panda_risc_v_wbck_mr.sv
// Directed bench for panda_risc_v_wbck_mr (RTR_WIDTH=2): vector table for squash,
// collision and count, plus hand sequences for CSR back-pressure and reset.
module tb_panda_risc_v_wbck_mr;
    import panda_risc_v_pkg::*;

    localparam int RW = 2;

    logic          clk, sys_reset;
    logic [1:0]    lane_vld, is_csr, cancel, grant;
    logic [9:0]    rd_id;
    logic [63:0]   fu_res;
    logic [23:0]   csr_waddr;
    logic [3:0]    csr_type;
    logic [63:0]   csr_mask;
    logic          bdcst_vld, bdcst_rdy;
    logic [1:0]    rf_wen;
    logic [9:0]    rf_waddr;
    logic [63:0]   rf_din;
    logic          c_wen, c_rdy, c_pend;
    logic [11:0]   c_addr;
    logic [1:0]    c_type;
    logic [31:0]   c_mask;
    logic [1:0]    rtr_cnt;

    int n_cmp = 0;
    int n_err = 0;

    panda_risc_v_wbck_mr #(.RTR_WIDTH(RW), .FU_RES_WIDTH(32)) dut (
        .clk                      (clk),
        .sys_reset                (sys_reset),
        .rob_rtr_lane_vld         (lane_vld),
        .rob_rtr_rd_id            (rd_id),
        .rob_rtr_is_csr_rw_inst   (is_csr),
        .rob_rtr_cancel           (cancel),
        .rob_rtr_fu_res           (fu_res),
        .rob_rtr_csr_waddr        (csr_waddr),
        .rob_rtr_csr_upd_type     (csr_type),
        .rob_rtr_csr_upd_mask_v   (csr_mask),
        .rob_rtr_bdcst_vld        (bdcst_vld),
        .rob_rtr_bdcst_rdy        (bdcst_rdy),
        .rob_rtr_excpt_proc_grant (grant),
        .reg_file_wen             (rf_wen),
        .reg_file_waddr           (rf_waddr),
        .reg_file_din             (rf_din),
        .csr_atom_wen             (c_wen),
        .csr_atom_rdy             (c_rdy),
        .csr_atom_waddr           (c_addr),
        .csr_atom_upd_type        (c_type),
        .csr_atom_upd_mask_v      (c_mask),
        .csr_wbck_pend            (c_pend),
        .rtr_cnt                  (rtr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        bv;
        logic [1:0]  lv;
        logic [4:0]  rd0, rd1;
        logic [31:0] r0, r1;
        logic [1:0]  cn, gr;
        logic [1:0]  ewen;
        logic [9:0]  ewaddr;
        logic [63:0] edin;
        logic [1:0]  ecnt;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bdcst_vld = 1'b0; lane_vld = '0; is_csr = '0; cancel = '0; grant = '0;
        rd_id = '0; fu_res = '0; csr_waddr = '0; csr_type = '0; csr_mask = '0;
    endtask

    // Lane-0 CSR group with rd=x0.
    task automatic drive_csr(input logic [11:0] a, input logic [1:0] t, input logic [31:0] m);
        idle_inputs();
        bdcst_vld = 1'b1; lane_vld = 2'b01; is_csr = 2'b01;
        csr_waddr = {12'h0, a}; csr_type = {2'b00, t}; csr_mask = {32'h0, m};
    endtask

    initial begin
        idle_inputs();
        c_rdy     = 1'b1;
        sys_reset = 1'b1;
        tick(); tick();
        check("reset_rf_wen", 64'(rf_wen), 64'd0);
        check("reset_csr_wen", 64'(c_wen), 64'd0);
        check("reset_pend", 64'(c_pend), 64'd0);
        check("reset_rtr_cnt", 64'(rtr_cnt), 64'd0);
        sys_reset = 1'b0;
        tick();

        vt[0]  = '{1'b1, 2'b11, 5'd3, 5'd5, 32'h11, 32'h22, 2'b00, 2'b00, 2'b11, {5'd5, 5'd3}, {32'h22, 32'h11}, 2'd2};
        vt[1]  = '{1'b1, 2'b11, 5'd7, 5'd7, 32'hA,  32'hB,  2'b00, 2'b00, 2'b10, {5'd7, 5'd0}, {32'hB,  32'h0},  2'd2};
        vt[2]  = '{1'b1, 2'b11, 5'd3, 5'd5, 32'h11, 32'h22, 2'b00, 2'b01, 2'b00, 10'd0,        64'd0,             2'd0};
        vt[3]  = '{1'b1, 2'b11, 5'd3, 5'd5, 32'h11, 32'h22, 2'b00, 2'b10, 2'b01, {5'd0, 5'd3}, {32'h0,  32'h11}, 2'd1};
        vt[4]  = '{1'b1, 2'b11, 5'd3, 5'd5, 32'h11, 32'h22, 2'b01, 2'b00, 2'b10, {5'd5, 5'd0}, {32'h22, 32'h0},  2'd1};
        vt[5]  = '{1'b1, 2'b11, 5'd0, 5'd9, 32'h33, 32'h44, 2'b00, 2'b00, 2'b10, {5'd9, 5'd0}, {32'h44, 32'h0},  2'd2};
        vt[6]  = '{1'b1, 2'b10, 5'd3, 5'd5, 32'h11, 32'h22, 2'b00, 2'b00, 2'b10, {5'd5, 5'd0}, {32'h22, 32'h0},  2'd1};
        vt[7]  = '{1'b0, 2'b11, 5'd3, 5'd5, 32'h11, 32'h22, 2'b00, 2'b00, 2'b00, 10'd0,        64'd0,             2'd0};
        vt[8]  = '{1'b1, 2'b01, 5'd3, 5'd5, 32'h11, 32'h22, 2'b00, 2'b10, 2'b01, {5'd0, 5'd3}, {32'h0,  32'h11}, 2'd1};
        vt[9]  = '{1'b1, 2'b11, 5'd7, 5'd7, 32'hA,  32'hB,  2'b10, 2'b00, 2'b01, {5'd0, 5'd7}, {32'h0,  32'hA},  2'd1};
        vt[10] = '{1'b1, 2'b11, 5'd4, 5'd4, 32'h5,  32'h6,  2'b00, 2'b11, 2'b00, 10'd0,        64'd0,             2'd0};

        // Outputs are checked one edge after drive with inputs held, which is
        // correct for both the registered and combinational RF port builds.
        foreach (vt[i]) begin
            idle_inputs();
            bdcst_vld = vt[i].bv; lane_vld = vt[i].lv;
            rd_id = {vt[i].rd1, vt[i].rd0}; fu_res = {vt[i].r1, vt[i].r0};
            cancel = vt[i].cn; grant = vt[i].gr;
            tick();
            check($sformatf("v%0d_wen", i), 64'(rf_wen), 64'(vt[i].ewen));
            check($sformatf("v%0d_waddr", i),
                  64'(rf_waddr & {{5{vt[i].ewen[1]}}, {5{vt[i].ewen[0]}}}), 64'(vt[i].ewaddr));
            check($sformatf("v%0d_din", i),
                  rf_din & {{32{vt[i].ewen[1]}}, {32{vt[i].ewen[0]}}}, vt[i].edin);
            check($sformatf("v%0d_cnt", i), 64'(rtr_cnt), 64'(vt[i].ecnt));
        end
        idle_inputs();
        tick();

        // CSR back-pressure: held for 3 cycles, then drained.
        c_rdy = 1'b0;
        drive_csr(12'h300, CSR_UPD_SET, 32'hDEAD);
        #1;
        check("csr1_rdy_empty", 64'(bdcst_rdy), 64'd1);
        tick();
        idle_inputs();
        check("csr1_cnt", 64'(rtr_cnt), 64'd1);
        check("csr1_addr", 64'(c_addr), 64'h300);
        check("csr1_type", 64'(c_type), 64'(CSR_UPD_SET));
        check("csr1_mask", 64'(c_mask), 64'hDEAD);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("csr1_hold%0d_wen", c), 64'(c_wen), 64'd1);
            check($sformatf("csr1_hold%0d_pend", c), 64'(c_pend), 64'd1);
            check($sformatf("csr1_hold%0d_rdy", c), 64'(bdcst_rdy), 64'd0);
            check($sformatf("csr1_hold%0d_addr", c), 64'(c_addr), 64'h300);
            tick();
        end
        c_rdy = 1'b1;
        #1;
        check("csr1_rdy_drain", 64'(bdcst_rdy), 64'd1);
        tick();
        check("csr1_pend_clr", 64'(c_pend), 64'd0);
        check("csr1_wen_clr", 64'(c_wen), 64'd0);

        // Drain and reload in the same cycle.
        c_rdy = 1'b0;
        drive_csr(12'h300, CSR_UPD_WRITE, 32'h1);
        tick();
        c_rdy = 1'b1;
        drive_csr(12'h305, CSR_UPD_CLR, 32'h55);
        #1;
        check("csr2_rdy", 64'(bdcst_rdy), 64'd1);
        tick();
        idle_inputs();
        check("csr2_pend", 64'(c_pend), 64'd1);
        check("csr2_addr", 64'(c_addr), 64'h305);
        check("csr2_type", 64'(c_type), 64'(CSR_UPD_CLR));
        check("csr2_mask", 64'(c_mask), 64'h55);
        tick();
        check("csr2_drained", 64'(c_pend), 64'd0);

        // Reset discards a pending CSR write.
        c_rdy = 1'b0;
        drive_csr(12'h341, CSR_UPD_WRITE, 32'hBEEF);
        tick();
        idle_inputs();
        check("rst_pre_pend", 64'(c_pend), 64'd1);
        sys_reset = 1'b1;
        tick();
        check("rst_csr_wen", 64'(c_wen), 64'd0);
        check("rst_rf_wen", 64'(rf_wen), 64'd0);
        check("rst_cnt", 64'(rtr_cnt), 64'd0);
        check("rst_addr", 64'(c_addr), 64'd0);
        sys_reset = 1'b0;
        c_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rst_post%0d_wen", c), 64'(c_wen), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
